// File: rtl/mov_seq_if.sv
// Decoder <-> move-sequencer handshake and register-file control bundle.
interface mov_seq_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  start;
  logic [1:0]            mode;
  logic [REG_ADDR_W-1:0] src;
  logic [REG_ADDR_W-1:0] dst;
  logic [REG_ADDR_W-1:0] src_sel;
  logic                  src_oe;
  logic                  imm_oe;
  logic [REG_ADDR_W-1:0] dst_sel;
  logic                  dst_we;
  logic                  pc_inc;
  logic                  busy;
  logic                  done;
  logic                  err;

  // decoder side
  modport master (
    output start, mode, src, dst,
    input  src_sel, src_oe, imm_oe, dst_sel, dst_we, pc_inc, busy, done, err
  );

  // sequencer side
  modport slave (
    input  start, mode, src, dst,
    output src_sel, src_oe, imm_oe, dst_sel, dst_we, pc_inc, busy, done, err
  );
endinterface

// File: rtl/mov_seq.sv
// Move-class register-transfer sequencer: MOV, MOVI and SWAP via scratch reg.
// All outputs decode registered state and captured fields only.
module mov_seq #(
  parameter int REG_ADDR_W = 3,
  parameter int WE_CYC     = 1,
  parameter int TMP_IDX    = 7
) (
  input  logic     clk,
  input  logic     reset,
  mov_seq_if.slave bus
);
  localparam logic [1:0]            M_MOV  = 2'b00;
  localparam logic [1:0]            M_MOVI = 2'b01;
  localparam logic [1:0]            M_SWAP = 2'b10;
  localparam logic [1:0]            M_ILL  = 2'b11;
  localparam logic [REG_ADDR_W-1:0] TMP    = REG_ADDR_W'(TMP_IDX);
  localparam logic [7:0]            W8     = 8'(WE_CYC);

  typedef enum logic [2:0] {IDLE, FETCH, XFER, HOLD, REL, PCINC, DONE, RECOV} state_t;

  state_t                state, nxt;
  logic [1:0]            mode_q;
  logic [REG_ADDR_W-1:0] src_q, dst_q;
  logic                  rej_q;
  logic [1:0]            step;
  logic [7:0]            cnt;
  logic                  rej_in;

  // Instruction is rejected before any transfer if it is illegal or would
  // clobber the scratch register during a swap.
  assign rej_in = (bus.mode == M_ILL) ||
                  ((bus.mode == M_SWAP) && ((bus.src == TMP) || (bus.dst == TMP)));

  // Next-state decode.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.start) begin
               if (rej_in)                nxt = PCINC;
               else if (bus.mode == M_MOVI) nxt = FETCH;
               else                       nxt = XFER;
             end
      FETCH: nxt = XFER;
      XFER:  if (cnt == 8'd1) nxt = HOLD;
      HOLD:  nxt = REL;
      REL:   nxt = ((mode_q == M_SWAP) && (step != 2'd2)) ? XFER : PCINC;
      PCINC: nxt = DONE;
      DONE:  nxt = RECOV;
      RECOV: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, captured instruction fields, pulse-width and swap-step counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mode_q <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      rej_q  <= 1'b0;
      step   <= '0;
      cnt    <= '0;
    end else begin
      state <= nxt;
      if ((state == IDLE) && bus.start) begin
        mode_q <= bus.mode;
        src_q  <= bus.src;
        dst_q  <= bus.dst;
        rej_q  <= rej_in;
        step   <= '0;
      end
      if ((nxt == XFER) && (state != XFER)) cnt <= W8;
      else if (state == XFER)               cnt <= cnt - 8'd1;
      if ((state == REL) && (nxt == XFER))  step <= step + 2'd1;
    end
  end

  // Output decode; selects are only driven while a transfer is in flight.
  always_comb begin
    bus.src_sel = '0;
    bus.dst_sel = '0;
    bus.src_oe  = 1'b0;
    bus.imm_oe  = 1'b0;
    bus.dst_we  = 1'b0;
    bus.pc_inc  = (state == FETCH) || (state == PCINC);
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.err     = (state == DONE) && rej_q;
    if ((state == XFER) || (state == HOLD) || (state == REL)) begin
      if (mode_q == M_SWAP) begin
        case (step)
          2'd0:    begin bus.src_sel = src_q; bus.dst_sel = TMP;   end
          2'd1:    begin bus.src_sel = dst_q; bus.dst_sel = src_q; end
          default: begin bus.src_sel = TMP;   bus.dst_sel = dst_q; end
        endcase
      end else begin
        // MOVI has no source register; its operand comes off the immediate bus.
        bus.src_sel = (mode_q == M_MOVI) ? '0 : src_q;
        bus.dst_sel = dst_q;
      end
    end
    if ((state == XFER) || (state == HOLD)) begin
      bus.src_oe = (mode_q != M_MOVI);
      bus.imm_oe = (mode_q == M_MOVI);
    end
    bus.dst_we = (state == XFER);
  end
endmodule

// File: tb/tb_mov_seq.sv
// Self-checking bench for mov_seq: directed plan cases plus random
// instructions against a cycle-list reference built from the timing rules.
module tb_mov_seq;
  logic clk = 1'b0;
  logic reset;
  logic st1, st3;
  logic [1:0] mode;
  logic [2:0] src, dst;

  int nchk = 0;
  int nfail = 0;

  // expected packed output per cycle after acceptance:
  // {busy,done,err,pc_inc,src_oe,imm_oe,dst_we,src_sel[2:0],dst_sel[2:0]}
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  mov_seq_if #(.REG_ADDR_W(3)) b1 ();
  mov_seq_if #(.REG_ADDR_W(3)) b3 ();

  assign b1.start = st1;
  assign b1.mode  = mode;
  assign b1.src   = src;
  assign b1.dst   = dst;
  assign b3.start = st3;
  assign b3.mode  = mode;
  assign b3.src   = src;
  assign b3.dst   = dst;

  mov_seq #(.REG_ADDR_W(3), .WE_CYC(1), .TMP_IDX(7)) u1 (.clk(clk), .reset(reset), .bus(b1));
  mov_seq #(.REG_ADDR_W(3), .WE_CYC(3), .TMP_IDX(7)) u3 (.clk(clk), .reset(reset), .bus(b3));

  logic [12:0] obs1, obs3;
  assign obs1 = {b1.busy, b1.done, b1.err, b1.pc_inc, b1.src_oe, b1.imm_oe, b1.dst_we, b1.src_sel, b1.dst_sel};
  assign obs3 = {b3.busy, b3.done, b3.err, b3.pc_inc, b3.src_oe, b3.imm_oe, b3.dst_we, b3.src_sel, b3.dst_sel};

  function automatic logic [12:0] pk(bit bsy, bit dn, bit er, bit pc, bit soe, bit ioe, bit we,
                                     logic [2:0] ss, logic [2:0] ds);
    return {bsy, dn, er, pc, soe, ioe, we, ss, ds};
  endfunction

  // one register transfer: W write cycles, one hold, one release
  task automatic xf(int w, logic [2:0] s, logic [2:0] d, bit imm);
    for (int k = 0; k < w; k++) exp_q.push_back(pk(1, 0, 0, 0, !imm, imm, 1, s, d));
    exp_q.push_back(pk(1, 0, 0, 0, !imm, imm, 0, s, d));
    exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, s, d));
  endtask

  task automatic build(int w, logic [1:0] m, logic [2:0] s, logic [2:0] d);
    exp_q.delete();
    if (m == 2'b11 || (m == 2'b10 && (s == 3'd7 || d == 3'd7))) begin
      exp_q.push_back(pk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(1, 1, 1, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      if (m == 2'b01) begin
        exp_q.push_back(pk(1, 0, 0, 1, 0, 0, 0, 0, 0));
        xf(w, 3'd0, d, 1);
      end else if (m == 2'b10) begin
        xf(w, s, 3'd7, 0);
        xf(w, d, s, 0);
        xf(w, 3'd7, d, 0);
      end else begin
        xf(w, s, d, 0);
      end
      exp_q.push_back(pk(1, 0, 0, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic chk(string tag, logic [12:0] o, logic [12:0] e);
    nchk++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %b required %b", tag, o, e);
    end
  endtask

  // Issue one instruction to the W=1 (w==1) or W=3 DUT and check every cycle.
  // With abuse set, start is pulsed and fields are scrambled while busy.
  task automatic run(int w, logic [1:0] m, logic [2:0] s, logic [2:0] d, bit abuse, string tag);
    int nd;
    logic [12:0] o;
    build(w, m, s, d);
    mode = m; src = s; dst = d;
    if (w == 1) st1 = 1'b1; else st3 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; st3 = 1'b0;
    if (abuse) begin mode = 2'($urandom); src = 3'($urandom); dst = 3'($urandom); end
    nd = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      o = (w == 1) ? obs1 : obs3;
      nd += int'(o[11]);
      chk($sformatf("%s cyc%0d", tag, i + 1), o, exp_q[i]);
      if (abuse && i < exp_q.size() - 1) begin
        if (w == 1) st1 = 1'($urandom); else st3 = 1'($urandom);
        mode = 2'($urandom); src = 3'($urandom); dst = 3'($urandom);
      end else begin
        st1 = 1'b0; st3 = 1'b0;
      end
    end
    @(negedge clk);
    o = (w == 1) ? obs1 : obs3;
    chk($sformatf("%s idle", tag), o, 13'd0);
    nchk++;
    assert (nd == 1) else begin
      nfail++;
      $error("FAIL %s done_count: observed %0d required 1", tag, nd);
    end
  endtask

  initial begin
    reset = 1'b1; st1 = 1'b0; st3 = 1'b0; mode = '0; src = '0; dst = '0;
    #1;
    chk("reset u1", obs1, 13'd0);
    chk("reset u3", obs3, 13'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset u1", obs1, 13'd0);
    chk("post-reset u3", obs3, 13'd0);

    // directed plan cases
    run(1, 2'b00, 3'd2, 3'd5, 1'b0, "mov_w1");
    run(3, 2'b01, 3'd6, 3'd1, 1'b0, "movi_w3");
    run(1, 2'b10, 3'd1, 3'd4, 1'b0, "swap_w1");
    run(1, 2'b11, 3'd3, 3'd2, 1'b0, "rej_ill");
    run(3, 2'b10, 3'd2, 3'd7, 1'b0, "rej_swap_dst");
    run(1, 2'b10, 3'd7, 3'd0, 1'b0, "rej_swap_src");
    run(3, 2'b00, 3'd4, 3'd4, 1'b0, "mov_same");
    run(3, 2'b10, 3'd5, 3'd5, 1'b0, "swap_same");
    run(1, 2'b00, 3'd2, 3'd5, 1'b1, "mov_abuse");
    run(3, 2'b10, 3'd0, 3'd6, 1'b1, "swap_abuse");

    // reset in cycle 5 of a SWAP
    build(1, 2'b10, 3'd1, 3'd4);
    mode = 2'b10; src = 3'd1; dst = 3'd4; st1 = 1'b1;
    @(posedge clk); #1; st1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("swap_pre_rst cyc%0d", i + 1), obs1, exp_q[i]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_reset", obs1, 13'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("after_rst cyc%0d", i), obs1, 13'd0);
    end
    run(1, 2'b00, 3'd3, 3'd6, 1'b0, "mov_after_rst");

    // random instructions on either DUT
    for (int n = 0; n < 24; n++) begin
      automatic int w = ($urandom_range(0, 1) == 0) ? 1 : 3;
      run(w, 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
